// File: rtl/special_op_resolver_if.sv
// Decode-to-resolver instruction bus plus writeback and fetch-redirect handshakes.
// slave modport is the resolver side; master is the decode/regfile/fetch side.
interface special_op_resolver_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_sel;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic [4:0]      in_rd;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            redir_valid;
  logic            redir_ack;
  logic [XLEN-1:0] redir_target;

  modport slave (
    input  in_valid, in_sel, in_pc, in_imm, in_rs1, in_rd, wb_ready, redir_ack,
    output in_ready, wb_valid, wb_rd, wb_data, redir_valid, redir_target
  );

  modport master (
    output in_valid, in_sel, in_pc, in_imm, in_rs1, in_rd, wb_ready, redir_ack,
    input  in_ready, wb_valid, wb_rd, wb_data, redir_valid, redir_target
  );
endinterface

// File: rtl/special_op_resolver.sv
// Resolves JAL/JALR/LUI/AUIPC into a writeback value and a fetch redirect.
// Optional macro SPECIAL_MISALIGN_CHECK_EN traps jumps whose target has bit 1 set.
module special_op_resolver #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  special_op_resolver_if.slave bus,
  output logic                 misalign_err,
  output logic [CNT_W-1:0]     resolved_count
);

  localparam logic [2:0]       SEL_LUI = 3'b100;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SPECIAL_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, ERR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1} state_t;
`endif

  state_t state_q, state_d;

  logic            rdy_q, rdy_d;
  logic            wb_valid_q, wb_valid_d;
  logic            redir_valid_q, redir_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            cnt_inc;

  logic            accept;
  logic            is_special, is_jump, is_jalr, is_lui;
  logic [XLEN-1:0] pc_plus4, pc_plus_imm, rs1_plus_imm, jump_tgt, wb_val;

  // Datapath for the instruction currently offered by decode
  always_comb begin
    is_special   = bus.in_sel[2];
    is_jump      = bus.in_sel[2] & bus.in_sel[1];
    is_jalr      = &bus.in_sel;
    is_lui       = (bus.in_sel == SEL_LUI);
    pc_plus4     = bus.in_pc + XLEN'(4);
    pc_plus_imm  = bus.in_pc + bus.in_imm;
    rs1_plus_imm = bus.in_rs1 + bus.in_imm;
    jump_tgt     = is_jalr ? {rs1_plus_imm[XLEN-1:1], 1'b0} : pc_plus_imm;
    if (is_jump) begin
      wb_val = pc_plus4;
    end else if (is_lui) begin
      wb_val = bus.in_imm;
    end else begin
      wb_val = pc_plus_imm;
    end
  end

  assign accept = bus.in_valid & rdy_q;

`ifdef SPECIAL_MISALIGN_CHECK_EN
  logic err_q, err_d;
  logic misalign_c;
  assign misalign_c = is_jump & jump_tgt[1];
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    wb_valid_d    = wb_valid_q;
    redir_valid_d = redir_valid_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redir_tgt_d   = redir_tgt_q;
    cnt_inc       = 1'b0;
`ifdef SPECIAL_MISALIGN_CHECK_EN
    err_d         = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef SPECIAL_MISALIGN_CHECK_EN
        if (accept && is_special && misalign_c) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else
`endif
        if (accept && is_special) begin
          wb_rd_d       = bus.in_rd;
          wb_data_d     = wb_val;
          wb_valid_d    = (bus.in_rd != 5'd0);
          redir_valid_d = is_jump;
          if (is_jump) begin
            redir_tgt_d = jump_tgt;
          end
          // LUI/AUIPC to x0 have nothing to present and retire at once
          if ((bus.in_rd == 5'd0) && !is_jump) begin
            cnt_inc = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        wb_valid_d    = wb_valid_q & ~bus.wb_ready;
        redir_valid_d = redir_valid_q & ~bus.redir_ack;
        if (!wb_valid_d && !redir_valid_d) begin
          state_d = IDLE;
          cnt_inc = 1'b1;
        end
      end
`ifdef SPECIAL_MISALIGN_CHECK_EN
      ERR: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE);
    cnt_d = (cnt_inc && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rdy_q         <= 1'b0;
      wb_valid_q    <= 1'b0;
      redir_valid_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
      redir_tgt_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      wb_valid_q    <= wb_valid_d;
      redir_valid_q <= redir_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redir_tgt_q   <= redir_tgt_d;
      cnt_q         <= cnt_d;
    end
  end

`ifdef SPECIAL_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign bus.in_ready     = rdy_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_target = redir_tgt_q;
  assign resolved_count   = cnt_q;

endmodule
